trap_sequencer: RTL and testbench

- Trap controller for the SPARC-style datapath.
- Collects synchronous exception requests, software-trap (Ticc) requests and external interrupt levels, and selects the highest-priority one.
- Produces the 8-bit trap type (tt), then sequences trap entry over fixed cycles: window decrement, save PC/nPC into the new window's locals, vector fetch to TBA|tt.
- Sits beside the PSR/TBR registers and the register file write port; the pipeline is stalled for the whole sequence.

---
 rtl/trap_sequencer_pkg.sv | 35 +++
 rtl/trap_sequencer_if.sv | 45 ++++
 rtl/trap_priority_enc.sv | 50 +++++
 rtl/trap_sequencer.sv | 124 ++++++++++++
 tb/tb_trap_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer: FSM state encoding,
// the synchronous-exception trap-type table and the tt base constants.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WIN,
    ST_SAVE_PC,
    ST_SAVE_NPC,
    ST_VECTOR,
    ST_ERROR
  } state_t;

  localparam logic [7:0] TT_IRQ_BASE = 8'h10;
  localparam logic [7:0] TT_SW_BASE  = 8'h80;

  // Index 0 is the highest-priority exception line.
  localparam logic [7:0] EXC_TT [0:7] = '{
    8'h01,  // instruction_access_exception
    8'h02,  // illegal_instruction
    8'h03,  // privileged_instruction
    8'h04,  // fp_disabled
    8'h05,  // window_overflow
    8'h06,  // window_underflow
    8'h07,  // mem_address_not_aligned
    8'h09   // data_access_exception
  };

  function automatic logic [7:0] exc_tt(input int unsigned idx);
    logic [2:0] sel;
    sel = idx[2:0];
    return (idx < 8) ? EXC_TT[sel] : 8'h00;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Request/strobe bundle between the pipeline and the trap sequencer.
// Optional counter outputs exist only when TRAP_SEQ_COUNT_EN is defined.
interface trap_sequencer_if #(
  parameter int unsigned NUM_EXC = 8
);
  logic [NUM_EXC-1:0] exc_req;
  logic               sw_trap_req;
  logic [6:0]         sw_trap_num;
  logic [3:0]         irl;
  logic [3:0]         pil;
  logic               et;
  logic [7:0]         tt_out;
  logic               tt_we;
  logic               cwp_dec;
  logic               psr_trap_upd;
  logic               rf_we;
  logic [4:0]         rf_addr;
  logic               rf_sel_npc;
  logic               pc_load;
  logic               stall;
  logic               error_mode;
`ifdef TRAP_SEQ_COUNT_EN
  logic [15:0]        trap_count;
  logic               last_was_irq;
`endif

  modport master (
    output exc_req, sw_trap_req, sw_trap_num, irl, pil, et,
    input  tt_out, tt_we, cwp_dec, psr_trap_upd, rf_we, rf_addr,
           rf_sel_npc, pc_load, stall, error_mode
`ifdef TRAP_SEQ_COUNT_EN
    , input trap_count, last_was_irq
`endif
  );

  modport slave (
    input  exc_req, sw_trap_req, sw_trap_num, irl, pil, et,
    output tt_out, tt_we, cwp_dec, psr_trap_upd, rf_we, rf_addr,
           rf_sel_npc, pc_load, stall, error_mode
`ifdef TRAP_SEQ_COUNT_EN
    , output trap_count, last_was_irq
`endif
  );

endinterface

// File: rtl/trap_priority_enc.sv
// Combinational trap priority select: exceptions (lowest index first),
// then software trap, then a qualifying external interrupt.
module trap_priority_enc
  import trap_pkg::*;
#(
  parameter int unsigned NUM_EXC = 8
) (
  input  logic [NUM_EXC-1:0] exc_req,
  input  logic               sw_trap_req,
  input  logic [6:0]         sw_trap_num,
  input  logic [3:0]         irl,
  input  logic [3:0]         pil,
  input  logic               et,
  output logic               valid,
  output logic [7:0]         tt,
  output logic               is_irq
);

  logic       exc_hit;
  logic [7:0] exc_sel;
  logic       irq_ok;

  // Pick the winning request and form its trap type.
  always_comb begin
    exc_hit = 1'b0;
    exc_sel = '0;
    valid   = 1'b0;
    tt      = '0;
    is_irq  = 1'b0;
    irq_ok  = et && (irl != 4'h0) && ((irl > pil) || (irl == 4'hF));
    for (int unsigned i = 0; i < NUM_EXC; i++) begin
      if (exc_req[i] && !exc_hit) begin
        exc_hit = 1'b1;
        exc_sel = exc_tt(i);
      end
    end
    if (exc_hit) begin
      valid = 1'b1;
      tt    = exc_sel;
    end else if (sw_trap_req) begin
      valid = 1'b1;
      tt    = TT_SW_BASE | {1'b0, sw_trap_num};
    end else if (irq_ok) begin
      valid  = 1'b1;
      tt     = TT_IRQ_BASE | {4'h0, irl};
      is_irq = 1'b1;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry sequencer: selects the highest-priority trap in IDLE and steps
// WIN -> SAVE_PC -> SAVE_NPC -> VECTOR with registered strobes; a trap taken
// with ET=0 parks in ERROR until reset.
// Optional build macro: TRAP_SEQ_COUNT_EN (trap_count / last_was_irq).
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned NUM_EXC    = 8,
  parameter int unsigned RF_PC_REG  = 17,
  parameter int unsigned RF_NPC_REG = 18
) (
  input logic             clk,
  input logic             reset,
  trap_sequencer_if.slave bus
);

  state_t     state_q, state_d;
  logic       sel_valid;
  logic [7:0] sel_tt;
  logic       sel_irq;
  logic       enter_win;

  logic [7:0] tt_q;
  logic       tt_we_q, cwp_dec_q, psr_upd_q, rf_we_q, rf_sel_npc_q;
  logic [4:0] rf_addr_q;
  logic       pc_load_q, stall_q, error_q;

  trap_priority_enc #(.NUM_EXC(NUM_EXC)) u_enc (
    .exc_req     (bus.exc_req),
    .sw_trap_req (bus.sw_trap_req),
    .sw_trap_num (bus.sw_trap_num),
    .irl         (bus.irl),
    .pil         (bus.pil),
    .et          (bus.et),
    .valid       (sel_valid),
    .tt          (sel_tt),
    .is_irq      (sel_irq)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid && bus.et)        state_d = ST_WIN;
        else if (sel_valid && !sel_irq) state_d = ST_ERROR;
      end
      ST_WIN:      state_d = ST_SAVE_PC;
      ST_SAVE_PC:  state_d = ST_SAVE_NPC;
      ST_SAVE_NPC: state_d = ST_VECTOR;
      ST_VECTOR:   state_d = ST_IDLE;
      ST_ERROR:    state_d = ST_ERROR;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign enter_win = (state_q == ST_IDLE) && (state_d == ST_WIN);

  // Outputs are decoded from the next state and registered, so each strobe
  // appears in the cycle the FSM occupies the corresponding state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tt_q         <= '0;
      tt_we_q      <= 1'b0;
      cwp_dec_q    <= 1'b0;
      psr_upd_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_sel_npc_q <= 1'b0;
      pc_load_q    <= 1'b0;
      stall_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (enter_win) tt_q <= sel_tt;
      tt_we_q      <= (state_d == ST_SAVE_NPC);
      cwp_dec_q    <= (state_d == ST_WIN);
      psr_upd_q    <= (state_d == ST_WIN);
      rf_we_q      <= (state_d == ST_SAVE_PC) || (state_d == ST_SAVE_NPC);
      rf_addr_q    <= (state_d == ST_SAVE_PC)  ? 5'(RF_PC_REG)  :
                      (state_d == ST_SAVE_NPC) ? 5'(RF_NPC_REG) : '0;
      rf_sel_npc_q <= (state_d == ST_SAVE_NPC);
      pc_load_q    <= (state_d == ST_VECTOR);
      stall_q      <= (state_d != ST_IDLE);
      error_q      <= (state_d == ST_ERROR);
    end
  end

  assign bus.tt_out       = tt_q;
  assign bus.tt_we        = tt_we_q;
  assign bus.cwp_dec      = cwp_dec_q;
  assign bus.psr_trap_upd = psr_upd_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_addr      = rf_addr_q;
  assign bus.rf_sel_npc   = rf_sel_npc_q;
  assign bus.pc_load      = pc_load_q;
  assign bus.stall        = stall_q;
  assign bus.error_mode   = error_q;

`ifdef TRAP_SEQ_COUNT_EN
  logic [15:0] count_q;
  logic        last_irq_q;

  // Count trap entries (ERROR entries excluded) and remember interrupt origin.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      last_irq_q <= 1'b0;
    end else if (enter_win) begin
      count_q    <= count_q + 16'd1;
      last_irq_q <= sel_irq;
    end
  end

  assign bus.trap_count   = count_q;
  assign bus.last_was_irq = last_irq_q;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: table of single-trap vectors plus
// hand-written sequences for reset mid-entry and back-to-back entry.
module tb_trap_sequencer;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_TRAP = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct {
    logic [7:0] exc;
    logic       sw;
    logic [6:0] num;
    logic [3:0] irl;
    logic [3:0] pil;
    logic       et;
    logic [1:0] kind;
    logic [7:0] tt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [15];

  always #5 clk = ~clk;

  trap_sequencer_if #(.NUM_EXC(8)) bus ();

  trap_sequencer #(.NUM_EXC(8), .RF_PC_REG(17), .RF_NPC_REG(18)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.exc_req     = '0;
    bus.sw_trap_req = 1'b0;
    bus.sw_trap_num = '0;
    bus.irl         = '0;
    bus.pil         = '0;
    bus.et          = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.tt_out, bus.tt_we, bus.cwp_dec, bus.psr_trap_upd, bus.rf_we,
                 bus.rf_addr, bus.rf_sel_npc, bus.pc_load, bus.stall, bus.error_mode}, 32'h0);
`ifdef TRAP_SEQ_COUNT_EN
    check({name, "_cnt"}, {bus.trap_count, 15'h0, bus.last_was_irq}, 32'h0);
`endif
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    do_reset();
    bus.exc_req     = v.exc;
    bus.sw_trap_req = v.sw;
    bus.sw_trap_num = v.num;
    bus.irl         = v.irl;
    bus.pil         = v.pil;
    bus.et          = v.et;
    step();
    if (v.kind == K_NONE) begin
      check({tag, "_none_out"}, {bus.stall, bus.cwp_dec, bus.error_mode, bus.tt_out}, 32'h0);
      step();
      check({tag, "_none_stall"}, {bus.stall, bus.cwp_dec}, 32'h0);
    end else if (v.kind == K_TRAP) begin
      // WIN
      check({tag, "_win_tt"}, bus.tt_out, v.tt);
      check({tag, "_win"}, {bus.cwp_dec, bus.psr_trap_upd, bus.stall, bus.rf_we, bus.pc_load, bus.tt_we}, 32'b111000);
`ifdef TRAP_SEQ_COUNT_EN
      check({tag, "_count"}, bus.trap_count, 32'd1);
      check({tag, "_irq"}, bus.last_was_irq, (v.exc == 8'h0 && !v.sw) ? 32'd1 : 32'd0);
`endif
      step();  // SAVE_PC
      check({tag, "_spc"}, {bus.cwp_dec, bus.psr_trap_upd, bus.stall, bus.rf_we, bus.rf_sel_npc, bus.tt_we, bus.pc_load}, 32'b0011000);
      check({tag, "_spc_addr"}, bus.rf_addr, 32'd17);
      step();  // SAVE_NPC
      check({tag, "_snpc"}, {bus.stall, bus.rf_we, bus.rf_sel_npc, bus.tt_we, bus.pc_load}, 32'b11110);
      check({tag, "_snpc_addr"}, bus.rf_addr, 32'd18);
      step();  // VECTOR
      check({tag, "_vec"}, {bus.stall, bus.pc_load, bus.rf_we, bus.tt_we, bus.cwp_dec}, 32'b11000);
      step();  // IDLE again; request still held but must not have re-triggered
      check({tag, "_idle"}, {bus.stall, bus.pc_load, bus.cwp_dec, bus.rf_we}, 32'h0);
      check({tag, "_tt_hold"}, bus.tt_out, v.tt);
      clear_inputs();
    end else begin
      check({tag, "_err"}, {bus.error_mode, bus.stall, bus.cwp_dec, bus.psr_trap_upd}, 32'b1100);
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
        step();
        check({tag, "_err_hold"}, {bus.error_mode, bus.stall, bus.rf_we, bus.pc_load, bus.cwp_dec}, 32'b11000);
      end
`ifdef TRAP_SEQ_COUNT_EN
      check({tag, "_err_cnt"}, bus.trap_count, 32'd0);
`endif
      reset = 1'b1;
      step();
      reset = 1'b0;
      check({tag, "_err_rst"}, {bus.error_mode, bus.stall}, 32'h0);
    end
  endtask

  initial begin
    //                exc     sw    num    irl   pil   et    kind    tt
    vecs[0]  = '{8'h04, 1'b0, 7'h00, 4'h0, 4'h0, 1'b1, K_TRAP, 8'h03};
    vecs[1]  = '{8'h82, 1'b1, 7'h05, 4'hF, 4'h0, 1'b1, K_TRAP, 8'h02};
    vecs[2]  = '{8'h00, 1'b1, 7'h7F, 4'h0, 4'h0, 1'b1, K_TRAP, 8'hFF};
    vecs[3]  = '{8'h00, 1'b1, 7'h05, 4'h0, 4'h0, 1'b1, K_TRAP, 8'h85};
    vecs[4]  = '{8'h00, 1'b0, 7'h00, 4'h5, 4'h5, 1'b1, K_NONE, 8'h00};
    vecs[5]  = '{8'h00, 1'b0, 7'h00, 4'h6, 4'h5, 1'b1, K_TRAP, 8'h16};
    vecs[6]  = '{8'h00, 1'b0, 7'h00, 4'hF, 4'hF, 1'b1, K_TRAP, 8'h1F};
    vecs[7]  = '{8'h00, 1'b0, 7'h00, 4'hF, 4'h0, 1'b0, K_NONE, 8'h00};
    vecs[8]  = '{8'h00, 1'b0, 7'h00, 4'h0, 4'h0, 1'b1, K_NONE, 8'h00};
    vecs[9]  = '{8'h80, 1'b0, 7'h00, 4'h0, 4'h0, 1'b1, K_TRAP, 8'h09};
    vecs[10] = '{8'h01, 1'b1, 7'h22, 4'h0, 4'h0, 1'b1, K_TRAP, 8'h01};
    vecs[11] = '{8'h10, 1'b0, 7'h00, 4'h0, 4'h0, 1'b0, K_ERR,  8'h00};
    vecs[12] = '{8'h00, 1'b1, 7'h03, 4'h0, 4'h0, 1'b0, K_ERR,  8'h00};
    vecs[13] = '{8'h00, 1'b0, 7'h00, 4'h3, 4'h7, 1'b1, K_NONE, 8'h00};
    vecs[14] = '{8'h00, 1'b1, 7'h03, 4'h9, 4'h0, 1'b1, K_TRAP, 8'h83};

    clear_inputs();
    step();
    step();
    check_all_zero("reset_state");
    reset = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted while the FSM sits in SAVE_PC.
    do_reset();
    bus.exc_req = 8'h01;
    bus.et      = 1'b1;
    step();
    check("mid_win", bus.cwp_dec, 32'd1);
    step();
    check("mid_spc", {bus.rf_we, bus.rf_addr}, {26'h0, 1'b1, 5'd17});
    reset = 1'b1;
    clear_inputs();
    step();
    check_all_zero("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_after", {bus.cwp_dec, bus.psr_trap_upd, bus.rf_we, bus.tt_we, bus.pc_load, bus.stall}, 32'h0);
    end

    // Request held past VECTOR: one stall-free IDLE cycle, then a new entry.
    do_reset();
    bus.exc_req = 8'h40;
    bus.et      = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("b2b_vec", bus.pc_load, 32'd1);
    step();
    check("b2b_gap", {bus.stall, bus.cwp_dec}, 32'h0);
    step();
    check("b2b_reentry", {bus.cwp_dec, bus.stall, bus.tt_out}, {22'h0, 1'b1, 1'b1, 8'h07});
`ifdef TRAP_SEQ_COUNT_EN
    check("b2b_count", bus.trap_count, 32'd2);
`endif
    clear_inputs();
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
